// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and defaults for the memory access unit
package mips_pkg;

    typedef enum logic [1:0] {
        LM_WORD = 2'b00,
        LM_LBU  = 2'b01,
        LM_LB   = 2'b10
    } load_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } mau_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - little-endian byte lane select with zero/sign extension
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  mode,
    output logic [31:0] result
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        // mode 11 is not a byte mode and falls through to the full word
        case (mode)
            LM_LBU:  result = {24'h000000, byte_sel};
            LM_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store bus master with timeout
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_lb,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    mau_state_t  state, next_state;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  lb_q;
    logic [7:0]  wait_cnt;
    logic [31:0] aligned_data;
    logic        misaligned_in;
    logic        timed_out;

    // byte modes may use any lane; only word-width accesses need alignment
    assign misaligned_in = (req_addr[1:0] != 2'b00) && (req_lb != LM_LBU) && (req_lb != LM_LB);
    assign timed_out     = (wait_cnt == TIMEOUT_CNT);

    load_align u_load_align (
        .word   (mem_rdata),
        .lane   (addr_q[1:0]),
        .mode   (lb_q),
        .result (aligned_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = misaligned_in ? ST_RESP : ST_BUS;
            ST_BUS:  if (mem_ack || timed_out) next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lb_q     <= '0;
            wait_cnt <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        lb_q     <= req_lb;
                        wait_cnt <= '0;
                        if (misaligned_in) begin
                            rsp_err  <= 1'b1;
                            rsp_data <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    // an ack arriving in the final wait cycle still wins over timeout
                    if (mem_ack) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= write_q ? 32'h0 : aligned_data;
                    end else if (timed_out) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign mem_req   = (state == ST_BUS);
    assign mem_we    = (state == ST_BUS) && write_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed plus randomized check against a reference model
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_lb;
    logic        busy, rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_lb    (req_lb),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference: outcome follows from alignment rule, ack delay vs TIMEOUT and lane extraction.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] lb, input int ack_dly, input logic [31:0] rd);
        logic        mis, exp_err, seen;
        int          exp_bus, bus;
        logic [31:0] exp_data, b;
        mis = (a[1:0] != 2'b00) && !(lb == 2'd1 || lb == 2'd2);
        if (mis) begin
            exp_bus = 0; exp_err = 1'b1; exp_data = 0;
        end else if (ack_dly <= TO) begin
            exp_bus = ack_dly + 1;
            exp_err = 1'b0;
            b = (rd >> (8 * a[1:0])) & 32'hFF;
            if (w)            exp_data = 0;
            else if (lb == 1) exp_data = b;
            else if (lb == 2) exp_data = (b >= 128) ? b - 256 : b;
            else              exp_data = rd;
        end else begin
            exp_bus = TO + 1; exp_err = 1'b1; exp_data = 0;
        end

        chk("idle_busy", busy, 0);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_lb = lb;
        step;
        bus = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom; req_lb = 2'($urandom);
            chk("busy", busy, 1);
            if (mem_req) begin
                bus++;
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_we", mem_we, w);
                chk("mem_wdata", mem_wdata, wd);
                mem_ack   = (bus - 1 == ack_dly);
                mem_rdata = mem_ack ? rd : $urandom;
            end else begin
                chk("mem_we_off", mem_we, 0);
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                chk("latency", 32'(cyc), 32'(exp_bus + 1));
                chk("bus_cycles", 32'(bus), 32'(exp_bus));
                chk("rsp_err", rsp_err, exp_err);
                chk("rsp_data", rsp_data, exp_data);
                req_valid = 1'b0;
            end
            step;
        end
        chk("rsp_seen", seen, 1);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("busy_after", busy, 0);
        chk("mem_req_after", mem_req, 0);
        chk("rsp_data_held", rsp_data, exp_data);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_wdata = 0;
        req_lb = 0; mem_ack = 1'b0; mem_rdata = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        step; step;
        reset = 1'b0;
        step;

        do_access(1'b0, 32'h100, 32'h0, 2'd0, 0, 32'h8899AABB);
        do_access(1'b0, 32'h103, 32'h0, 2'd2, 1, 32'h80112233);
        do_access(1'b0, 32'h103, 32'h0, 2'd1, 0, 32'h80112233);
        do_access(1'b1, 32'h20, 32'hDEADBEEF, 2'd0, 3, 32'h12345678);
        do_access(1'b0, 32'h102, 32'h0, 2'd0, 0, 32'h5555AAAA);
        do_access(1'b1, 32'h101, 32'h0, 2'd3, 0, 32'h5555AAAA);
        do_access(1'b0, 32'h200, 32'h0, 2'd0, 99, 32'h0);
        do_access(1'b0, 32'h204, 32'h0, 2'd3, TO, 32'hCAFEF00D);

        // reset while the bus is waiting: request drops at once, no response follows
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_lb = 2'd0; mem_ack = 1'b0;
        step;
        req_valid = 1'b0;
        step;
        chk("pre_rst_mem_req", mem_req, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        step;
        chk("rst_hold_rsp_valid", rsp_valid, 0);
        reset = 1'b0;
        step;
        chk("post_rst_rsp_valid", rsp_valid, 0);
        do_access(1'b0, 32'h44, 32'h0, 2'd0, 0, 32'h0BADCAFE);

        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom), $urandom, $urandom, 2'($urandom),
                      int'($urandom_range(0, TO + 2)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum bus wait in cycles before an access is aborted.
REQ-002 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  access request from the control FSM memory states.
REQ-005 SHALL have port req_write  in  1  1 = word store, 0 = load.
REQ-006 SHALL have port req_addr  in  32  byte address.
REQ-007 SHALL have port req_wdata  in  32  store data.
REQ-008 SHALL have port req_lb  in  2  load mode: 00 word, 01 LBU, 10 LB, 11 treated as word.
REQ-009 SHALL have port busy  out  1  high while an accepted access is outstanding.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_data  out  32  load result, held until the next rsp_valid.
REQ-012 SHALL have port rsp_err  out  1  qualifies rsp_valid: misaligned word access or timeout.
REQ-013 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1, forming the memory bus.

Function
REQ-014 SHALL implement states IDLE, BUS, RESP.
REQ-015 IDLE: req_valid=1 SHALL capture req_write, req_addr, req_wdata, req_lb into registers and move to BUS; a misaligned word access (addr[1:0]!=00, mode 00/11, load or store) SHALL go directly to RESP with err set and no bus cycle.
REQ-016 busy SHALL be high in BUS and RESP; req_valid outside IDLE SHALL be ignored.
REQ-017 BUS: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=captured req_write, mem_wdata=captured wdata, all stable until the ack cycle or timeout.
REQ-018 mem_ack SHALL be sampled only while mem_req=1; ack in the first BUS cycle is valid; mem_ack outside BUS SHALL be ignored.
REQ-019 On ack, mem_rdata SHALL be captured and the unit SHALL move to RESP.
REQ-020 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack; when it equals TIMEOUT without ack, the unit SHALL move to RESP with err set and data 0.
REQ-021 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; minimum latency request-to-rsp_valid is 2 cycles (ack in first BUS cycle).
REQ-022 Load data: mode 00/11 -> full word; byte lane = addr[1:0], lane 0 = bits 7:0 (little-endian); LBU zero-extends, LB sign-extends bit 7 of the lane.
REQ-023 Stores SHALL return rsp_data=0 with rsp_valid; err loads SHALL return rsp_data=0.
REQ-024 mem_req, mem_we SHALL be 0 in IDLE and RESP.

Reset
REQ-025 reset SHALL force IDLE immediately, including mid-BUS (mem_req drops asynchronously, outstanding access abandoned, no rsp_valid).
REQ-026 Reset values: busy 0, rsp_valid 0, rsp_data 0, rsp_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, counter 0.

Structure
REQ-027 Shared package mips_pkg SHALL hold the load-mode enum (LM_WORD, LM_LBU, LM_LB), the unit state enum, and default TIMEOUT.
REQ-028 Byte selection/extension SHALL be a combinational sub-module load_align (inputs word, lane, mode; output 32-bit result).

Verification
REQ-029 LW addr 0x100, ack in first BUS cycle, rdata 0x8899AABB -> rsp_valid 2 cycles after req, data 0x8899AABB, err 0.
REQ-030 LB addr 0x103, rdata 0x80112233 -> mem_addr 0x100, data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-031 SW addr 0x20 wdata 0xDEADBEEF, ack after 3 cycles -> mem_we=1, mem_wdata stable 4 cycles, rsp_valid data 0 err 0.
REQ-032 LW addr 0x102 -> no mem_req, rsp_valid next cycle err 1 data 0.
REQ-033 No ack, TIMEOUT=4 -> mem_req held 5 cycles, then rsp_valid err 1.
REQ-034 reset asserted during BUS -> mem_req 0 same cycle, no rsp_valid; new LW after release completes normally.
